// File: rtl/mult_operand_sequencer.sv
// Operand FIFO and issue sequencer in front of the 32-cycle Multiplicator.
// Products are returned in order through a one-entry valid/ready buffer.
module mult_operand_sequencer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [31:0]       iOp_A,
   input  logic [31:0]       iOp_B,
   input  logic              iOp_Valid,
   output logic              oOp_Ready,
   output logic [31:0]       oMult_A,
   output logic [31:0]       oMult_B,
   output logic              oMult_Valid,
   input  logic              iMult_Idle,
   input  logic              iMult_Done,
   output logic              oMult_Ack,
   input  logic [31:0]       iMult_Result,
   output logic [31:0]       oResult,
   output logic              oResult_Valid,
   input  logic              iResult_Ready,
   output logic [ADDR_W:0]   oCount,
   output logic              oBusy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ACK
   } state_t;

   localparam logic [ADDR_W:0]   FULL    = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0]   CNT_ONE = 1;
   localparam logic [ADDR_W-1:0] PTR_ONE = 1;

   state_t            state;
   state_t            stateNext;
   logic [31:0]       memA [DEPTH];
   logic [31:0]       memB [DEPTH];
   logic [ADDR_W-1:0] wrPtr;
   logic [ADDR_W-1:0] rdPtr;
   logic [ADDR_W:0]   count;
   logic              push;
   logic              pop;
   logic              capture;

   assign oOp_Ready = (count < FULL);
   assign push      = iOp_Valid && oOp_Ready;
   assign pop       = (state == S_IDLE) && (count != '0) && iMult_Idle;
   assign capture   = (state == S_WAIT) && iMult_Done &&
                      (!oResult_Valid || iResult_Ready);

   assign oMult_Valid = (state == S_ISSUE);
   assign oMult_Ack   = (state == S_ACK);
   assign oCount      = count;
   assign oBusy       = (state != S_IDLE) || (count != '0);

   // Operand storage; contents are qualified by the pointers and count.
   always_ff @(posedge Clock) begin
      if (push) begin
         memA[wrPtr] <= iOp_A;
         memB[wrPtr] <= iOp_B;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop keeps count.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PTR_ONE;
         if (pop)  rdPtr <= rdPtr + PTR_ONE;
         if (push && !pop)
            count <= count + CNT_ONE;
         else if (pop && !push)
            count <= count - CNT_ONE;
      end
   end

   // Operands are latched only on the pop that starts an issue.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         oMult_A <= '0;
         oMult_B <= '0;
      end else if (pop) begin
         oMult_A <= memA[rdPtr];
         oMult_B <= memB[rdPtr];
      end
   end

   // Sequencer state register.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= stateNext;
   end

   // Next-state logic for the issue / wait / acknowledge sequence.
   always_comb begin
      stateNext = state;
      unique case (state)
         S_IDLE:  if (pop)     stateNext = S_ISSUE;
         S_ISSUE:              stateNext = S_WAIT;
         S_WAIT:  if (capture) stateNext = S_ACK;
         S_ACK:                stateNext = S_IDLE;
         default:              stateNext = S_IDLE;
      endcase
   end

   // Output buffer; a capture in the same cycle as a consume wins.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         oResult       <= '0;
         oResult_Valid <= 1'b0;
      end else if (capture) begin
         oResult       <= iMult_Result;
         oResult_Valid <= 1'b1;
      end else if (iResult_Ready) begin
         oResult_Valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Bench for mult_operand_sequencer with a behavioural multiplier and
// an in-order operand/product scoreboard checked every cycle.
module tb_mult_operand_sequencer;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;

   logic              Clock = 1'b0;
   logic              Reset = 1'b0;
   logic [31:0]       iOp_A = '0;
   logic [31:0]       iOp_B = '0;
   logic              iOp_Valid = 1'b0;
   logic              oOp_Ready;
   logic [31:0]       oMult_A;
   logic [31:0]       oMult_B;
   logic              oMult_Valid;
   logic              iMult_Idle;
   logic              iMult_Done;
   logic              oMult_Ack;
   logic [31:0]       iMult_Result;
   logic [31:0]       oResult;
   logic              oResult_Valid;
   logic              iResult_Ready = 1'b1;
   logic [ADDR_W:0]   oCount;
   logic              oBusy;

   mult_operand_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .Clock(Clock),
      .Reset(Reset),
      .iOp_A(iOp_A),
      .iOp_B(iOp_B),
      .iOp_Valid(iOp_Valid),
      .oOp_Ready(oOp_Ready),
      .oMult_A(oMult_A),
      .oMult_B(oMult_B),
      .oMult_Valid(oMult_Valid),
      .iMult_Idle(iMult_Idle),
      .iMult_Done(iMult_Done),
      .oMult_Ack(oMult_Ack),
      .iMult_Result(iMult_Result),
      .oResult(oResult),
      .oResult_Valid(oResult_Valid),
      .iResult_Ready(iResult_Ready),
      .oCount(oCount),
      .oBusy(oBusy)
   );

   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mul32(input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] p;
      p = {32'b0, a} * {32'b0, b};
      return p[31:0];
   endfunction

   // Behavioural Multiplicator: IDLE -> 32 busy cycles -> DONE until ack.
   int          mSt = 0;
   int          mCnt = 0;
   logic [31:0] mRes = '0;
   logic        stubBusy = 1'b0;

   always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         mSt  <= 0;
         mCnt <= 0;
         mRes <= '0;
      end else begin
         case (mSt)
            0: if (oMult_Valid) begin
               mRes <= mul32(oMult_A, oMult_B);
               mCnt <= 32;
               mSt  <= 1;
            end
            1: begin
               mCnt <= mCnt - 1;
               if (mCnt == 1) mSt <= 2;
            end
            default: if (oMult_Ack) mSt <= 0;
         endcase
      end
   end

   assign iMult_Idle   = (mSt == 0) && !stubBusy;
   assign iMult_Done   = (mSt == 2);
   assign iMult_Result = mRes;

   // Scoreboard: accepted operands, issued products, occupancy.
   logic [63:0] opQ[$];
   logic [31:0] resQ[$];
   int          mCount = 0;
   int          consumed = 0;
   int          acks = 0;
   logic        prevValid = 1'b0;
   logic        prevAck = 1'b0;
   logic        prevHold = 1'b0;
   logic [31:0] prevRes = '0;

   always @(negedge Clock) begin
      logic [63:0] e;
      if (Reset) begin
         opQ.delete();
         resQ.delete();
         mCount    = 0;
         prevValid = 1'b0;
         prevAck   = 1'b0;
         prevHold  = 1'b0;
      end else begin
         if (oMult_Valid) begin
            chk("issue_single", prevValid, 0);
            chk("issue_has_op", opQ.size() > 0, 1);
            if (opQ.size() > 0) begin
               e = opQ.pop_front();
               chk("issue_A", oMult_A, e[63:32]);
               chk("issue_B", oMult_B, e[31:0]);
               resQ.push_back(mul32(e[63:32], e[31:0]));
               mCount--;
            end
         end
         if (oMult_Ack) begin
            chk("ack_single", prevAck, 0);
            acks++;
         end
         chk("count", oCount, mCount);
         chk("op_ready", oOp_Ready, mCount < DEPTH);
         if (prevHold) chk("result_hold", oResult, prevRes);
         if (oResult_Valid && iResult_Ready) begin
            chk("result_expected", resQ.size() > 0, 1);
            if (resQ.size() > 0) chk("result", oResult, resQ.pop_front());
            consumed++;
         end
         prevHold = oResult_Valid && !iResult_Ready;
         prevRes  = oResult;
         if (iOp_Valid && mCount < DEPTH) begin
            opQ.push_back({iOp_A, iOp_B});
            mCount++;
         end
         prevValid = oMult_Valid;
         prevAck   = oMult_Ack;
      end
   end

   task automatic pushOp(input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      iOp_A = a;
      iOp_B = b;
      iOp_Valid = 1'b1;
      while (!oOp_Ready && n < 200) begin
         @(posedge Clock); #1;
         n++;
      end
      chk("push_timeout", oOp_Ready, 1);
      @(posedge Clock); #1;
      iOp_Valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((oBusy || oResult_Valid) && n < budget) begin
         @(posedge Clock); #1;
         n++;
      end
      chk("drain_busy", oBusy, 0);
      chk("drain_valid", oResult_Valid, 0);
   endtask

   task automatic waitResult(input int budget);
      int n;
      n = 0;
      while (!oResult_Valid && n < budget) begin
         @(posedge Clock); #1;
         n++;
      end
      chk("result_timeout", oResult_Valid, 1);
   endtask

   initial begin
      int c0;
      int a0;
      int stale;
      #2 Reset = 1'b1;
      #1;
      chk("rst_ready", oOp_Ready, 1);
      chk("rst_count", oCount, 0);
      chk("rst_mvalid", oMult_Valid, 0);
      chk("rst_rvalid", oResult_Valid, 0);
      chk("rst_busy", oBusy, 0);
      chk("rst_multA", oMult_A, 0);
      chk("rst_result", oResult, 0);
      repeat (3) @(posedge Clock);
      #1 Reset = 1'b0;

      // Single op 7*6
      @(posedge Clock); #1;
      iOp_A = 7; iOp_B = 6; iOp_Valid = 1'b1;
      @(posedge Clock); #1;
      iOp_Valid = 1'b0;
      chk("t2_no_bypass", oMult_Valid, 0);
      chk("t2_count1", oCount, 1);
      @(posedge Clock); #1;
      chk("t2_issue", oMult_Valid, 1);
      chk("t2_opA", oMult_A, 7);
      @(posedge Clock); #1;
      chk("t2_issue_pulse", oMult_Valid, 0);
      waitResult(60);
      chk("t2_result", oResult, 42);
      chk("t2_ack", oMult_Ack, 1);
      @(posedge Clock); #1;
      chk("t2_ack_pulse", oMult_Ack, 0);
      drain(5);

      // Push while the head is popped
      iOp_A = 11; iOp_B = 12; iOp_Valid = 1'b1;
      @(posedge Clock); #1;
      iOp_A = 13; iOp_B = 14;
      @(posedge Clock); #1;
      iOp_Valid = 1'b0;
      chk("t5_count", oCount, 1);
      chk("t5_issue", oMult_Valid, 1);
      drain(150);

      // Reset while waiting on the multiplier
      pushOp(9, 9);
      repeat (10) @(posedge Clock);
      #3 Reset = 1'b1;
      #1;
      chk("t1_ready", oOp_Ready, 1);
      chk("t1_count", oCount, 0);
      chk("t1_busy", oBusy, 0);
      chk("t1_multA", oMult_A, 0);
      chk("t1_mvalid", oMult_Valid, 0);
      @(posedge Clock); #1 Reset = 1'b0;
      stale = 0;
      repeat (50) begin
         @(posedge Clock); #1;
         if (oResult_Valid) stale++;
      end
      chk("t1_no_stale", stale, 0);

      // Full FIFO with multiplier held busy
      stubBusy = 1'b1;
      pushOp(1, 2);
      pushOp(3, 4);
      pushOp(5, 6);
      pushOp(7, 8);
      iOp_A = 9; iOp_B = 10; iOp_Valid = 1'b1;
      repeat (3) @(posedge Clock);
      #1;
      chk("t3_count4", oCount, 4);
      chk("t3_not_ready", oOp_Ready, 0);
      stubBusy = 1'b0;
      iOp_Valid = 1'b0;
      pushOp(9, 10);
      drain(300);

      // Backpressure on the output buffer
      iResult_Ready = 1'b0;
      pushOp(3, 5);
      pushOp(1000, 1000);
      waitResult(60);
      chk("t4_first", oResult, 15);
      repeat (2) @(posedge Clock);
      a0 = acks;
      repeat (80) @(posedge Clock);
      #1;
      chk("t4_no_ack", acks, a0);
      chk("t4_mult_done", iMult_Done, 1);
      chk("t4_held", oResult, 15);
      iResult_Ready = 1'b1;
      @(posedge Clock); #1;
      chk("t4_second", oResult, 1000000);
      chk("t4_second_valid", oResult_Valid, 1);
      drain(20);

      // Ten pairs through the wrapping FIFO
      c0 = consumed;
      pushOp(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int i = 1; i < 10; i++) pushOp($urandom, $urandom);
      drain(600);
      chk("t6_products", consumed - c0, 10);
      chk("t6_opq_empty", opQ.size(), 0);
      chk("t6_resq_empty", resQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
